// File: rtl/l15_mem_responder.sv
// L1.5 stand-in responder: services one load/store at a time from a 64-bit-word
// memory, returns 16-byte lines on the big-endian response bus, acknowledges
// stores and sends the post-reset wake-up message.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   transducer_l15_val/rqtype/size/address/data   request from the initiator
//   transducer_l15_req_ack        initiator consumed the response
//   l15_transducer_header_ack     request accepted (high only while idle)
//   l15_transducer_ack            one-cycle acknowledge, cycle after capture
//   l15_transducer_val/returntype/data_0/data_1   response
module l15_mem_responder #(
  parameter int unsigned MEM_DWORDS   = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned RESP_LATENCY = 2,
  parameter int unsigned WAKE_DELAY   = 8,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transducer_l15_val,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic [2:0]  transducer_l15_size,
  input  logic [31:0] transducer_l15_address,
  input  logic [63:0] transducer_l15_data,
  input  logic        transducer_l15_req_ack,
  output logic        l15_transducer_header_ack,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_val,
  output logic [3:0]  l15_transducer_returntype,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1
);

  localparam int unsigned AW = (MEM_DWORDS > 1) ? $clog2(MEM_DWORDS) : 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] WAKE_LAST = CW'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);
  localparam logic [CW-1:0] LAT_LAST  = CW'((RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0);
  localparam logic [4:0] RQ_LOAD  = 5'd0;
  localparam logic [4:0] RQ_STORE = 5'd1;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_STORE = 4'b0100;
  localparam logic [3:0] RT_WAKE  = 4'b0111;

  typedef enum logic [2:0] {S_BOOT, S_WAKE, S_IDLE, S_LAT, S_RESP} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ack_q, ack_n;
  logic          val_q, val_n;
  logic [3:0]    rt_q, rt_n;
  logic [63:0]   d0_q, d0_n;
  logic [63:0]   d1_q, d1_n;
  logic          cap_c;

  // Captured request
  logic [4:0]    rq_q;
  logic [2:0]    size_q;
  logic [31:0]   addr_q;
  logic [63:0]   wdata_q;

  logic [63:0]   mem [MEM_DWORDS];

  // Address decode on the captured request (offset wraps modulo 2^32)
  logic [31:0]   offset_c;
  logic          ld_ok_c, st_in_range_c, aligned_c, store_ok_c, we_c;
  logic [AW-1:0] rd_idx0_c, rd_idx1_c, wr_idx_c;
  logic [7:0]    be_c;

  assign offset_c      = addr_q - BASE_ADDR;
  assign ld_ok_c       = (offset_c >> 4) < 32'(MEM_DWORDS / 2);
  assign st_in_range_c = (offset_c >> 3) < 32'(MEM_DWORDS);
  assign rd_idx0_c     = AW'((offset_c >> 4) << 1);
  assign rd_idx1_c     = rd_idx0_c | AW'(1);
  assign wr_idx_c      = AW'(offset_c >> 3);

  // Natural alignment; sizes above 8 bytes never qualify
  always_comb begin
    aligned_c = 1'b0;
    case (size_q)
      3'd0:    aligned_c = 1'b1;
      3'd1:    aligned_c = (addr_q[0] == 1'b0);
      3'd2:    aligned_c = (addr_q[1:0] == 2'b00);
      3'd3:    aligned_c = (addr_q[2:0] == 3'b000);
      default: aligned_c = 1'b0;
    endcase
  end

  // Byte-lane enables: bytes o .. o+2^size-1 of the addressed dword
  always_comb begin
    int unsigned lo;
    int unsigned nb;
    lo   = 32'(addr_q[2:0]);
    nb   = 32'(1) << size_q;
    be_c = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      be_c[k] = (k >= lo) && (k < lo + nb);
    end
  end

  assign store_ok_c = (rq_q == RQ_STORE) && aligned_c && st_in_range_c;
  // Commit in the first latency cycle (the ack cycle); a reset here drops it
  assign we_c = (state_q == S_LAT) && (cnt_q == '0) && store_ok_c && !rst;

  // Memory write, byte k lives at bits [63-8k : 56-8k]
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (be_c[k]) mem[wr_idx_c][8*(7-k) +: 8] <= wdata_q[8*(7-k) +: 8];
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ack_n   = 1'b0;
    val_n   = 1'b0;
    rt_n    = RT_LOAD;
    d0_n    = '0;
    d1_n    = '0;
    cap_c   = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q == WAKE_LAST) begin
          state_n = S_WAKE;
          cnt_n   = '0;
          val_n   = 1'b1;
          rt_n    = RT_WAKE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_WAKE: state_n = S_IDLE;
      S_IDLE: begin
        if (transducer_l15_val) begin
          cap_c   = 1'b1;
          ack_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_LAT;
        end
      end
      S_LAT: begin
        if (cnt_q == LAT_LAST) begin
          state_n = S_RESP;
          cnt_n   = '0;
          val_n   = 1'b1;
          if (rq_q == RQ_STORE) begin
            rt_n = RT_STORE;
          end else if (rq_q == RQ_LOAD && ld_ok_c) begin
            d0_n = mem[rd_idx0_c];
            d1_n = mem[rd_idx1_c];
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (transducer_l15_req_ack) begin
          state_n = S_IDLE;
        end else begin
          val_n = 1'b1;
          rt_n  = rt_q;
          d0_n  = d0_q;
          d1_n  = d1_q;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      val_q   <= 1'b0;
      rt_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ack_q   <= ack_n;
      val_q   <= val_n;
      rt_q    <= rt_n;
      d0_q    <= d0_n;
      d1_q    <= d1_n;
    end
  end

  // Request capture (datapath, no reset needed)
  always_ff @(posedge clk) begin
    if (cap_c && !rst) begin
      rq_q    <= transducer_l15_rqtype;
      size_q  <= transducer_l15_size;
      addr_q  <= transducer_l15_address;
      wdata_q <= transducer_l15_data;
    end
  end

  assign l15_transducer_header_ack = (state_q == S_IDLE) && !rst;
  assign l15_transducer_ack        = ack_q;
  assign l15_transducer_val        = val_q;
  assign l15_transducer_returntype = rt_q;
  assign l15_transducer_data_0     = d0_q;
  assign l15_transducer_data_1     = d1_q;

endmodule

// File: tb/tb_l15_mem_responder.sv
// Directed bench for l15_mem_responder: expected responses come from a small
// reference memory model and are queued when each request is driven.
module tb_l15_mem_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned MEMD = 4096;
  localparam int unsigned LAT  = 2;
  localparam int unsigned WAKE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0;
  logic [4:0]  req_type = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic        req_ack = 1'b0;
  logic        header_ack, ack, val;
  logic [3:0]  rt;
  logic [63:0] d0, d1;

  always #5 clk = ~clk;

  l15_mem_responder #(
    .MEM_DWORDS(MEMD), .BASE_ADDR(BASE), .RESP_LATENCY(LAT), .WAKE_DELAY(WAKE), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .transducer_l15_val(req_val), .transducer_l15_rqtype(req_type),
    .transducer_l15_size(req_size), .transducer_l15_address(req_addr),
    .transducer_l15_data(req_data), .transducer_l15_req_ack(req_ack),
    .l15_transducer_header_ack(header_ack), .l15_transducer_ack(ack),
    .l15_transducer_val(val), .l15_transducer_returntype(rt),
    .l15_transducer_data_0(d0), .l15_transducer_data_1(d1)
  );

  typedef struct packed {
    logic [3:0]  rt;
    logic [63:0] d0;
    logic [63:0] d1;
  } resp_t;

  resp_t       sb[$];
  logic [63:0] mdl [int unsigned];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: response contents and store side effects
  function automatic resp_t model(input logic [4:0] t, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [63:0] d);
    resp_t       r;
    logic [31:0] off;
    logic [63:0] w;
    int unsigned o, nb, idx, line;
    r   = '0;
    off = a - BASE;
    o   = 32'(a[2:0]);
    if (t == 5'd1) begin
      r.rt = 4'b0100;
      if (sz <= 3'd3) begin
        nb  = 32'(1) << sz;
        idx = off >> 3;
        if ((o % nb) == 0 && idx < MEMD) begin
          w = mdl[idx];
          for (int unsigned k = 0; k < 8; k++)
            if (k >= o && k < o + nb) w[8*(7-k) +: 8] = d[8*(7-k) +: 8];
          mdl[idx] = w;
        end
      end
    end else if (t == 5'd0) begin
      line = off >> 4;
      if (line < MEMD / 2) begin
        r.d0 = mdl[2*line];
        r.d1 = mdl[2*line + 1];
      end
    end
    return r;
  endfunction

  // Apply reset on the current cycle, check cleared outputs, then the wake-up
  task automatic reset_and_wake();
    rst = 1'b1;
    req_val = 1'b0;
    req_ack = 1'b0;
    @(negedge clk);
    chk("rst_val", 64'(val), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_hdr_ack", 64'(header_ack), 64'(0));
    chk("rst_rt", 64'(rt), 64'(0));
    chk("rst_d0", d0, 64'(0));
    chk("rst_d1", d1, 64'(0));
    rst = 1'b0;
    for (int i = 1; i <= int'(WAKE); i++) begin
      @(negedge clk);
      if (i < int'(WAKE)) begin
        chk("boot_val", 64'(val), 64'(0));
      end else begin
        chk("wake_val", 64'(val), 64'(1));
        chk("wake_rt", 64'(rt), 64'(4'b0111));
        chk("wake_d0", d0, 64'(0));
        chk("wake_d1", d1, 64'(0));
        chk("wake_hdr_ack", 64'(header_ack), 64'(0));
      end
    end
    @(negedge clk);
    chk("post_wake_val", 64'(val), 64'(0));
    chk("post_wake_hdr_ack", 64'(header_ack), 64'(1));
  endtask

  // One full transaction; hold = cycles req_ack is withheld, spam keeps val high
  task automatic do_req(input logic [4:0] t, input logic [2:0] sz, input logic [31:0] a,
                        input logic [63:0] d, input int hold, input bit spam);
    resp_t e;
    int    n;
    sb.push_back(model(t, sz, a, d));
    chk("hdr_ack_idle", 64'(header_ack), 64'(1));
    req_val  = 1'b1;
    req_type = t;
    req_size = sz;
    req_addr = a;
    req_data = d;
    @(negedge clk);
    if (!spam) req_val = 1'b0;
    req_addr = ~a;
    chk("ack_t1", 64'(ack), 64'(1));
    chk("val_t1", 64'(val), 64'(0));
    chk("hdr_ack_busy", 64'(header_ack), 64'(0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!val) chk("ack_single", 64'(ack), 64'(0));
    end while (!val && n < 20);
    req_val = 1'b0;
    chk("latency", 64'(n), 64'(LAT));
    chk("resp_seen", 64'(val), 64'(1));
    e = sb.pop_front();
    if (val) begin
      chk("resp_ack_low", 64'(ack), 64'(0));
      chk("resp_rt", 64'(rt), 64'(e.rt));
      chk("resp_d0", d0, e.d0);
      chk("resp_d1", d1, e.d1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_val", 64'(val), 64'(1));
        chk("hold_rt", 64'(rt), 64'(e.rt));
        chk("hold_d0", d0, e.d0);
        chk("hold_d1", d1, e.d1);
        chk("hold_hdr_ack", 64'(header_ack), 64'(0));
      end
      req_ack = 1'b1;
      @(negedge clk);
      req_ack = 1'b0;
      chk("drop_val", 64'(val), 64'(0));
      chk("drop_hdr_ack", 64'(header_ack), 64'(1));
    end
  endtask

  // Start a load, then reset while its response is being presented
  task automatic abort_load(input logic [31:0] a);
    int n;
    req_val  = 1'b1;
    req_type = 5'd0;
    req_size = 3'd0;
    req_addr = a;
    @(negedge clk);
    req_val = 1'b0;
    n = 0;
    while (!val && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_resp_seen", 64'(val), 64'(1));
    reset_and_wake();
  endtask

  initial begin
    @(negedge clk);
    reset_and_wake();

    // Preload four dwords
    do_req(5'd1, 3'd3, 32'h4000_0000, 64'h13000000_93000000, 0, 1'b0);
    do_req(5'd1, 3'd3, 32'h4000_0008, 64'h33000000_b3000000, 0, 1'b0);
    do_req(5'd1, 3'd3, 32'h4000_0010, 64'h11223344_55667788, 0, 1'b0);
    do_req(5'd1, 3'd3, 32'h4000_0018, 64'h99aabbcc_ddeeff00, 0, 1'b0);

    // Line load with low address bits ignored, response held 5 extra cycles
    do_req(5'd0, 3'd0, 32'h4000_0008, 64'h0, 5, 1'b0);

    // Partial 4B store into the low half, then read back; val re-asserted while busy
    do_req(5'd1, 3'd2, 32'h4000_0014, 64'h00000000_DEADBEEF, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_0010, 64'h0, 0, 1'b1);

    // Dropped stores: misaligned, oversize, out of range (would alias dword 0)
    do_req(5'd1, 3'd1, 32'h4000_0001, 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0);
    do_req(5'd1, 3'd4, 32'h4000_0008, 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0);
    do_req(5'd1, 3'd3, 32'h4000_8000, 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_0000, 64'h0, 0, 1'b0);

    // 1B and 2B stores into single lanes
    do_req(5'd1, 3'd0, 32'h4000_0003, 64'h000000A5_00000000, 0, 1'b0);
    do_req(5'd1, 3'd1, 32'h4000_0006, 64'h00000000_0000CAFE, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_0004, 64'h0, 1, 1'b0);

    // Last in-range line, then loads just below and just above the window
    do_req(5'd1, 3'd3, 32'h4000_7FF0, 64'h0123456789ABCDEF, 0, 1'b0);
    do_req(5'd1, 3'd3, 32'h4000_7FF8, 64'hFEDCBA9876543210, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_7FF0, 64'h0, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h3FFF_FFF0, 64'h0, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_8000, 64'h0, 0, 1'b0);

    // Unsupported request type
    do_req(5'd5, 3'd3, 32'h4000_0000, 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_0000, 64'h0, 0, 1'b0);

    // Reset during a response; committed data must survive
    abort_load(32'h4000_0010);
    do_req(5'd0, 3'd0, 32'h4000_0010, 64'h0, 0, 1'b0);
    do_req(5'd0, 3'd0, 32'h4000_0000, 64'h0, 0, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
